// File: rtl/distributor_sched.sv
// Round-robin write scheduler for the distributor's shared sample buffer.
// Optional sticky overflow flags are built only when DIST_SCHED_OVF_EN is defined.
module distributor_sched #(
  parameter int NCH   = 10,
  parameter int DW    = 8,
  parameter int AW    = 8,
  parameter int DEPTH = 256,
  parameter int CW    = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_clear,
  input  logic [NCH-1:0]    i_req,
  input  logic [NCH*DW-1:0] i_data,
  output logic              o_wr_en,
  output logic [CW-1:0]     o_wr_ch,
  output logic [AW-1:0]     o_wr_addr,
  output logic [DW-1:0]     o_wr_data,
  output logic [NCH-1:0]    o_grant,
  output logic [NCH-1:0]    o_start,
  output logic [NCH-1:0]    o_frame_done,
  output logic              o_busy,
  output logic [NCH-1:0]    o_ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [NCH-1:0]    pend_q, pend_d;
  logic [NCH*DW-1:0] hold_q, hold_d;
  logic [NCH*AW-1:0] addr_q, addr_d;
  logic [CW-1:0]     ptr_q, ptr_d;
  logic              wr_en_q, wr_en_d;
  logic [CW-1:0]     wr_ch_q, wr_ch_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [DW-1:0]     wr_data_q, wr_data_d;
  logic [NCH-1:0]    grant_q, grant_d;
  logic [NCH-1:0]    start_q, start_d;
  logic [NCH-1:0]    frame_done_q, frame_done_d;

  logic              gnt_vld;
  logic [CW-1:0]     gnt_ch;
  logic [CW:0]       scan;
  logic [AW-1:0]     gnt_addr;

  // Scan pending channels starting at the round-robin pointer, wrapping at NCH.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    scan    = '0;
    if (state_q != IDLE) begin
      for (int i = 0; i < NCH; i++) begin
        scan = {1'b0, ptr_q} + (CW+1)'(i);
        if (scan >= (CW+1)'(NCH)) scan = scan - (CW+1)'(NCH);
        if (!gnt_vld && pend_q[scan[CW-1:0]]) begin
          gnt_vld = 1'b1;
          gnt_ch  = scan[CW-1:0];
        end
      end
    end
  end

  assign gnt_addr = addr_q[gnt_ch*AW +: AW];

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    hold_d       = hold_q;
    addr_d       = addr_q;
    ptr_d        = ptr_q;
    wr_en_d      = 1'b0;
    wr_ch_d      = '0;
    wr_addr_d    = '0;
    wr_data_d    = '0;
    grant_d      = '0;
    start_d      = '0;
    frame_done_d = frame_done_q;

    if (gnt_vld) begin
      wr_en_d         = 1'b1;
      wr_ch_d         = gnt_ch;
      wr_addr_d       = gnt_addr;
      wr_data_d       = hold_q[gnt_ch*DW +: DW];
      grant_d[gnt_ch] = 1'b1;
      start_d[gnt_ch] = (gnt_addr == '0);
      pend_d[gnt_ch]  = 1'b0;
      if (gnt_addr == AW'(DEPTH-1)) begin
        addr_d[gnt_ch*AW +: AW] = '0;
        frame_done_d[gnt_ch]    = 1'b1;
      end else begin
        addr_d[gnt_ch*AW +: AW] = gnt_addr + 1'b1;
      end
      ptr_d = (gnt_ch == CW'(NCH-1)) ? '0 : gnt_ch + 1'b1;
    end

    // A channel being granted this cycle may accept its next sample at once.
    for (int k = 0; k < NCH; k++) begin
      if (i_req[k] && (!pend_q[k] || (gnt_vld && gnt_ch == CW'(k)))) begin
        pend_d[k]            = 1'b1;
        hold_d[k*DW +: DW]   = i_data[k*DW +: DW];
      end
    end

    case (state_q)
      IDLE:    if (i_enable) state_d = RUN;
      RUN:     if (!i_enable) state_d = (pend_d != '0) ? DRAIN : IDLE;
      DRAIN: begin
        if (i_enable)           state_d = RUN;
        else if (pend_d == '0)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (i_clear) begin
      state_d      = IDLE;
      pend_d       = '0;
      hold_d       = '0;
      addr_d       = '0;
      ptr_d        = '0;
      frame_done_d = '0;
      wr_en_d      = 1'b0;
      wr_ch_d      = '0;
      wr_addr_d    = '0;
      wr_data_d    = '0;
      grant_d      = '0;
      start_d      = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      hold_q       <= '0;
      addr_q       <= '0;
      ptr_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_ch_q      <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      grant_q      <= '0;
      start_q      <= '0;
      frame_done_q <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      hold_q       <= hold_d;
      addr_q       <= addr_d;
      ptr_q        <= ptr_d;
      wr_en_q      <= wr_en_d;
      wr_ch_q      <= wr_ch_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      grant_q      <= grant_d;
      start_q      <= start_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef DIST_SCHED_OVF_EN
  logic [NCH-1:0] ovf_q, ovf_d;

  // A request is dropped when its channel is still pending and not being granted.
  always_comb begin
    ovf_d = ovf_q;
    for (int k = 0; k < NCH; k++) begin
      if (i_req[k] && pend_q[k] && !(gnt_vld && gnt_ch == CW'(k))) ovf_d[k] = 1'b1;
    end
    if (i_clear) ovf_d = '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ovf_q <= '0;
    else       ovf_q <= ovf_d;
  end

  assign o_ovf = ovf_q;
`else
  assign o_ovf = '0;
`endif

  assign o_wr_en      = wr_en_q;
  assign o_wr_ch      = wr_ch_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_grant      = grant_q;
  assign o_start      = start_q;
  assign o_frame_done = frame_done_q;
  assign o_busy       = (state_q != IDLE) || (pend_q != '0);

endmodule
